// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types, blank constant and hex glyph table for the 7-segment scan controller
package seg7_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_BLANK = 7'h7F;

   // Active-low {g,f,e,d,c,b,a} glyphs for 0-9, A, b, C, d, E, F
   localparam seg_t HEX_SEG [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   typedef enum logic {
      BLANK = 1'b0,
      DRIVE = 1'b1
   } scan_state_t;

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational hex nibble to active-low segment pattern
module hex_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed common-anode 7-segment scanner with frame-aligned value commit
// Optional leading-zero suppression is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int N_DIGITS  = 4,
   parameter int CLK_HZ    = 100_000_000,
   parameter int SCAN_HZ   = 1000,
   parameter int BLANK_CYC = 2000
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  en_i,
   input  logic [4*N_DIGITS-1:0] data_i,
   input  logic [N_DIGITS-1:0]   dp_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   output logic [N_DIGITS-1:0]   an_o,
   output logic [6:0]            seg_o,
   output logic                  dp_o,
   output logic                  frame_o
);

   localparam int DIV = CLK_HZ / SCAN_HZ;
   localparam int CW  = $clog2(DIV);
   localparam int IW  = $clog2(N_DIGITS);
   localparam logic [CW-1:0]       CNT_LAST  = CW'(DIV - 1);
   localparam logic [CW-1:0]       CNT_BLANK = CW'(BLANK_CYC);
   localparam logic [IW-1:0]       IDX_LAST  = IW'(N_DIGITS - 1);
   localparam logic [N_DIGITS-1:0] AN_ONE    = N_DIGITS'(1);

   logic [CW-1:0]         cnt_q;
   logic [IW-1:0]         idx_q;
   logic [4*N_DIGITS-1:0] active_q, pend_q;
   logic [N_DIGITS-1:0]   active_dp_q, pend_dp_q;
   logic                  flag_q;
   logic [N_DIGITS-1:0]   an_q;
   logic [6:0]            seg_q;
   logic                  dp_q;

   scan_state_t state_d;
   logic        wrap_d;
   logic        commit_d;
   logic [6:0]  seg_dec;
   logic [6:0]  seg_sel;

   assign state_d  = (en_i && cnt_q >= CNT_BLANK) ? DRIVE : BLANK;
   assign wrap_d   = en_i && (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
   // While disabled the display is dark, so a pending value can be applied without tearing.
   assign commit_d = wrap_d || !en_i;

   hex_to_seg7 u_dec (
      .nibble_i (active_q[{idx_q, 2'b00} +: 4]),
      .seg_o    (seg_dec)
   );

`ifdef SEG7_LZ_BLANK_EN
   logic [N_DIGITS-1:0] lz_mask;
   logic                zero_run;

   always_comb begin
      lz_mask  = '0;
      zero_run = 1'b1;
      for (int k = N_DIGITS - 1; k >= 1; k--) begin
         zero_run   = zero_run & (active_q[4*k +: 4] == 4'h0);
         lz_mask[k] = zero_run;
      end
   end

   assign seg_sel = lz_mask[idx_q] ? SEG_BLANK : seg_dec;
`else
   assign seg_sel = seg_dec;
`endif

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q       <= '0;
         idx_q       <= '0;
         active_q    <= '0;
         active_dp_q <= '0;
         pend_q      <= '0;
         pend_dp_q   <= '0;
         flag_q      <= 1'b0;
         an_q        <= '1;
         seg_q       <= SEG_BLANK;
         dp_q        <= 1'b1;
      end else begin
         if (!en_i) begin
            cnt_q <= '0;
            idx_q <= '0;
         end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end

         if (state_d == DRIVE) begin
            an_q  <= ~(AN_ONE << idx_q);
            seg_q <= seg_sel;
            dp_q  <= ~active_dp_q[idx_q];
         end else begin
            an_q  <= '1;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
         end

         if (commit_d && flag_q) begin
            active_q    <= pend_q;
            active_dp_q <= pend_dp_q;
            flag_q      <= 1'b0;
         end else if (valid_i && !flag_q) begin
            pend_q    <= data_i;
            pend_dp_q <= dp_i;
            flag_q    <= 1'b1;
         end
      end
   end

   assign ready_o = ~flag_q;
   assign frame_o = wrap_d;
   assign an_o    = an_q;
   assign seg_o   = seg_q;
   assign dp_o    = dp_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - self-checking bench for seg7_scan_ctrl with a frame-phase reference model
module tb_seg7_scan_ctrl;

   localparam int N     = 4;
   localparam int DIV   = 10;
   localparam int BLK   = 2;
   localparam int FRAME = N * DIV;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic        en    = 1'b0;
   logic        valid = 1'b0;
   logic [15:0] data  = '0;
   logic [3:0]  dpi   = '0;
   logic        ready_w, dp_w, frame_w;
   logic [3:0]  an_w;
   logic [6:0]  seg_w;

   int n_checks = 0;
   int n_fail   = 0;

   // Lit segments of each hex glyph, by letter.
   string LIT [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                       "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

   int          phase;
   logic [15:0] m_act, m_pend;
   logic [3:0]  m_adp, m_pdp;
   bit          m_flag;
   logic [3:0]  m_an;
   logic [6:0]  m_seg;
   logic        m_dp;

   seg7_scan_ctrl #(
      .N_DIGITS  (N),
      .CLK_HZ    (1000),
      .SCAN_HZ   (100),
      .BLANK_CYC (BLK)
   ) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .en_i    (en),
      .data_i  (data),
      .dp_i    (dpi),
      .valid_i (valid),
      .ready_o (ready_w),
      .an_o    (an_w),
      .seg_o   (seg_w),
      .dp_o    (dp_w),
      .frame_o (frame_w)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] glyph(input logic [3:0] nib);
      logic [6:0] lit;
      string      s;
      lit = '0;
      s   = LIT[nib];
      for (int i = 0; i < s.len(); i++) lit[3'(s[i] - 8'd97)] = 1'b1;
      return ~lit;
   endfunction

   function automatic bit lz(input int k, input logic [15:0] act);
`ifdef SEG7_LZ_BLANK_EN
      return (k != 0) && ((act >> (4 * k)) == 16'h0);
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_step();
      int cnt, idx;
      bit commit;
      if (reset) begin
         phase = 0; m_act = '0; m_pend = '0; m_adp = '0; m_pdp = '0; m_flag = 0;
         m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1;
         return;
      end
      cnt = phase % DIV;
      idx = (phase / DIV) % N;
      if (en && cnt >= BLK) begin
         m_an  = ~(4'b0001 << idx);
         m_seg = lz(idx, m_act) ? 7'h7F : glyph(m_act[4*idx +: 4]);
         m_dp  = ~m_adp[idx];
      end else begin
         m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1;
      end
      commit = !en || (phase % FRAME == FRAME - 1);
      if (m_flag && commit) begin
         m_act = m_pend; m_adp = m_pdp; m_flag = 0;
      end else if (!m_flag && valid) begin
         m_pend = data; m_pdp = dpi; m_flag = 1;
      end
      phase = en ? phase + 1 : 0;
   endtask

   function automatic logic [13:0] exp_vec();
      logic fr;
      fr = (en && (phase % FRAME == FRAME - 1)) ? 1'b1 : 1'b0;
      return {m_an, m_seg, m_dp, fr, ~m_flag};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic wait_frame(output bit seen);
      seen = 0;
      for (int i = 0; i < 3 * FRAME && !seen; i++) begin
         tick();
         seen = frame_w;
      end
   endtask

   task automatic test_reset();
      reset = 1; en = 0; valid = 0;
      tick(); tick();
      n_checks++;
      if ({an_w, seg_w, dp_w, frame_w, ready_w} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_vals: got %h want %h", {an_w, seg_w, dp_w, frame_w, ready_w},
                  {4'hF, 7'h7F, 1'b1, 1'b0, 1'b1});
      end
      reset = 0;
   endtask

   task automatic test_scan();
      logic [6:0] exp_seg [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
      logic [3:0] exp_an;
      logic [6:0] s;
      logic       d;
      bit         seen;
      en = 1; valid = 1; data = 16'h1234; dpi = 4'b0101;
      tick();
      valid = 0;
      n_checks++;
      if (ready_w !== 1'b0) begin n_fail++; $display("FAIL scan_load_ready: got %b want 0", ready_w); end
      wait_frame(seen);
      n_checks++;
      if (!seen) begin n_fail++; $display("FAIL scan_frame_timeout: got 0 want 1"); end
      tick();
      for (int j = 0; j < FRAME; j++) begin
         tick();
         exp_an = (j % DIV < BLK) ? 4'hF : ~(4'b0001 << (j / DIV));
         s      = (j % DIV < BLK) ? 7'h7F : exp_seg[j / DIV];
         d      = (j % DIV < BLK) ? 1'b1 : ~dpi[j / DIV];
         n_checks++;
         if ({an_w, seg_w, dp_w} !== {exp_an, s, d}) begin
            n_fail++;
            $display("FAIL scan_pattern j=%0d: got %h want %h", j, {an_w, seg_w, dp_w}, {exp_an, s, d});
         end
         n_checks++;
         if ({an_w, seg_w, dp_w, frame_w, ready_w} !== exp_vec()) begin
            n_fail++;
            $display("FAIL scan_model j=%0d: got %h want %h", j, {an_w, seg_w, dp_w, frame_w, ready_w}, exp_vec());
         end
      end
   endtask

   task automatic test_handshake();
      bit seen;
      valid = 1; data = 16'h5678;
      tick();
      data = 16'hABCD;
      tick();
      n_checks++;
      if (ready_w !== 1'b0) begin n_fail++; $display("FAIL hs_full_ready: got %b want 0", ready_w); end
      wait_frame(seen);
      n_checks++;
      if (!seen || ready_w !== 1'b0) begin
         n_fail++; $display("FAIL hs_frame: got seen=%0d ready=%b want seen=1 ready=0", seen, ready_w);
      end
      tick();
      n_checks++;
      if (ready_w !== 1'b1) begin n_fail++; $display("FAIL hs_ready_rise: got %b want 1", ready_w); end
      tick();
      n_checks++;
      if (ready_w !== 1'b0) begin n_fail++; $display("FAIL hs_second_load: got %b want 0", ready_w); end
      valid = 0;
      tick(); tick();
      n_checks++;
      if ({an_w, seg_w} !== {4'hE, 7'h00}) begin
         n_fail++; $display("FAIL hs_old_value: got %h want %h", {an_w, seg_w}, {4'hE, 7'h00});
      end
      wait_frame(seen);
      repeat (4) tick();
      n_checks++;
      if ({an_w, seg_w} !== {4'hE, 7'h21}) begin
         n_fail++; $display("FAIL hs_new_value: got %h want %h", {an_w, seg_w}, {4'hE, 7'h21});
      end
      n_checks++;
      if ({an_w, seg_w, dp_w, frame_w, ready_w} !== exp_vec()) begin
         n_fail++; $display("FAIL hs_model: got %h want %h", {an_w, seg_w, dp_w, frame_w, ready_w}, exp_vec());
      end
   endtask

   task automatic test_same_cycle();
      bit seen;
      int k;
      wait_frame(seen);
      n_checks++;
      if (!seen || ready_w !== 1'b1) begin
         n_fail++; $display("FAIL sc_frame: got seen=%0d ready=%b want seen=1 ready=1", seen, ready_w);
      end
      valid = 1; data = 16'h9ABC;
      tick();
      valid = 0;
      n_checks++;
      if (ready_w !== 1'b0) begin n_fail++; $display("FAIL sc_loaded: got %b want 0", ready_w); end
      tick(); tick(); tick();
      n_checks++;
      if ({an_w, seg_w} !== {4'hE, 7'h21}) begin
         n_fail++; $display("FAIL sc_not_shown: got %h want %h", {an_w, seg_w}, {4'hE, 7'h21});
      end
      k = 0; seen = 0;
      for (int i = 0; i < 2 * FRAME && !seen; i++) begin
         tick(); k++; seen = frame_w;
      end
      n_checks++;
      if (!seen || k + 4 != FRAME) begin
         n_fail++; $display("FAIL sc_frame_gap: got %0d want %0d", k + 4, FRAME);
      end
      repeat (4) tick();
      n_checks++;
      if ({an_w, seg_w} !== {4'hE, 7'h46}) begin
         n_fail++; $display("FAIL sc_committed: got %h want %h", {an_w, seg_w}, {4'hE, 7'h46});
      end
   endtask

   task automatic test_enable();
      for (int i = 0; i < FRAME && (phase % DIV) != 5; i++) tick();
      valid = 1; data = 16'h0F0F;
      tick();
      valid = 0;
      n_checks++;
      if (ready_w !== 1'b0) begin n_fail++; $display("FAIL en_loaded: got %b want 0", ready_w); end
      en = 0;
      #1;
      n_checks++;
      if (frame_w !== 1'b0) begin n_fail++; $display("FAIL en_frame_low: got %b want 0", frame_w); end
      tick();
      n_checks++;
      if ({an_w, seg_w, dp_w, ready_w} !== {4'hF, 7'h7F, 1'b1, 1'b1}) begin
         n_fail++; $display("FAIL en_dark: got %h want %h", {an_w, seg_w, dp_w, ready_w}, {4'hF, 7'h7F, 1'b1, 1'b1});
      end
      repeat (3) begin
         tick();
         n_checks++;
         if ({an_w, seg_w, dp_w, frame_w, ready_w} !== exp_vec()) begin
            n_fail++; $display("FAIL en_idle_model: got %h want %h", {an_w, seg_w, dp_w, frame_w, ready_w}, exp_vec());
         end
      end
      en = 1;
      tick(); tick();
      n_checks++;
      if (an_w !== 4'hF) begin n_fail++; $display("FAIL en_restart_blank: got %h want f", an_w); end
      tick();
      n_checks++;
      if ({an_w, seg_w} !== {4'hE, 7'h0E}) begin
         n_fail++; $display("FAIL en_restart_drive: got %h want %h", {an_w, seg_w}, {4'hE, 7'h0E});
      end
   endtask

   task automatic test_reset_mid();
      repeat (13) tick();
      valid = 1; data = 16'h5555;
      tick();
      valid = 0;
      reset = 1;
      tick();
      n_checks++;
      if ({an_w, seg_w, dp_w, frame_w, ready_w} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b1}) begin
         n_fail++; $display("FAIL rst_mid_vals: got %h want %h", {an_w, seg_w, dp_w, frame_w, ready_w},
                            {4'hF, 7'h7F, 1'b1, 1'b0, 1'b1});
      end
      reset = 0;
      for (int j = 0; j < 2 * FRAME; j++) begin
         tick();
         if (an_w === 4'hE) begin
            n_checks++;
            if (seg_w !== 7'h40) begin n_fail++; $display("FAIL rst_mid_zero: got %h want 40", seg_w); end
         end
         n_checks++;
         if ({an_w, seg_w, dp_w, frame_w, ready_w} !== exp_vec()) begin
            n_fail++; $display("FAIL rst_mid_model j=%0d: got %h want %h", j, {an_w, seg_w, dp_w, frame_w, ready_w}, exp_vec());
         end
      end
   endtask

`ifdef SEG7_LZ_BLANK_EN
   task automatic test_lz();
      logic [6:0] exp_seg [4] = '{7'h40, 7'h12, 7'h7F, 7'h7F};
      logic [3:0] exp_an;
      logic [6:0] s;
      logic       d;
      bit         seen;
      valid = 1; data = 16'h0050; dpi = 4'b1000;
      tick();
      valid = 0;
      wait_frame(seen);
      tick();
      for (int j = 0; j < FRAME; j++) begin
         tick();
         exp_an = (j % DIV < BLK) ? 4'hF : ~(4'b0001 << (j / DIV));
         s      = (j % DIV < BLK) ? 7'h7F : exp_seg[j / DIV];
         d      = (j % DIV < BLK) ? 1'b1 : ((j / DIV) == 3 ? 1'b0 : 1'b1);
         n_checks++;
         if ({an_w, seg_w, dp_w} !== {exp_an, s, d}) begin
            n_fail++; $display("FAIL lz_pattern j=%0d: got %h want %h", j, {an_w, seg_w, dp_w}, {exp_an, s, d});
         end
      end
   endtask
`endif

   task automatic test_random();
      for (int i = 0; i < 800; i++) begin
         valid = ($urandom_range(0, 3) == 0);
         data  = 16'($urandom);
         dpi   = 4'($urandom);
         if ($urandom_range(0, 199) == 0) en = ~en;
         reset = ($urandom_range(0, 499) == 0);
         tick();
         n_checks++;
         if ({an_w, seg_w, dp_w, frame_w, ready_w} !== exp_vec()) begin
            n_fail++; $display("FAIL random_model i=%0d: got %h want %h", i, {an_w, seg_w, dp_w, frame_w, ready_w}, exp_vec());
         end
      end
      reset = 0; valid = 0; en = 1;
   endtask

   initial begin
      test_reset();
      test_scan();
      test_handshake();
      test_same_cycle();
      test_enable();
      test_reset_mid();
`ifdef SEG7_LZ_BLANK_EN
      test_lz();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
